note_detector: RTL and testbench

- Receive-side counterpart of the buzzer tone generator. Takes the square-wave audio line (period q = CLK_HZ/f clocks, high for about q/256 clocks, silence = held low).
- Measures the period between rising edges and identifies the note code 1..21 (C4..B6, same code map as the generator).
- Reports the note once it has been stable for STABLE_CNT periods. Used for loopback self-test of the music path and for driving a note display.

---
 rtl/music_pkg.sv | 25 ++
 rtl/note_detector_if.sv | 14 +
 rtl/note_period_search.sv | 73 +++++++
 rtl/note_detector.sv | 155 +++++++++++++++
 tb/tb_note_detector.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared music-path definitions: note code map, widths and detector FSM states.
// Note code k (1..21) maps to NOTE_HZ[k]; code 0 means silence / unrecognised.
package music_pkg;

    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 21;
    localparam int PERIOD_W  = 27;

    localparam int NOTE_HZ [1:NUM_NOTES] = '{
        262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698,
        784, 880, 988, 1046, 1175, 1318, 1397, 1568, 1760, 1976
    };

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        SRCH
    } det_state_e;

    // Nominal period in clocks for note code k (integer division).
    function automatic logic [PERIOD_W-1:0] note_period(input int clk_hz, input int k);
        return PERIOD_W'(clk_hz / NOTE_HZ[k]);
    endfunction

endpackage

// File: rtl/note_detector_if.sv
// Audio line in, note report out; master drives audio, slave is the detector.
interface note_detector_if;
    import music_pkg::*;

    logic                audio_in;
    logic [NOTE_W-1:0]   note;
    logic                note_valid;
    logic                note_change;
    logic [PERIOD_W-1:0] period;

    modport master (output audio_in, input note, note_valid, note_change, period);
    modport slave  (input audio_in, output note, note_valid, note_change, period);

endinterface

// File: rtl/note_period_search.sv
// Sequential scan of the 21-entry period table, one entry per clock.
// First entry whose tolerance window contains the period wins; 0 if none.
module note_period_search
    import music_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TOL_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    output logic                busy,
    output logic                done,
    output logic [NOTE_W-1:0]   code
);

    logic [PERIOD_W-1:0] lo_tab [32];
    logic [PERIOD_W-1:0] hi_tab [32];

    // Unused slots get an empty window so they can never match.
    for (genvar k = 0; k < 32; k++) begin : g_tab
        if (k >= 1 && k <= NUM_NOTES) begin : g_note
            localparam logic [PERIOD_W-1:0] Q = note_period(CLK_HZ, k);
            assign lo_tab[k] = Q - (Q >> TOL_SHIFT);
            assign hi_tab[k] = Q + (Q >> TOL_SHIFT);
        end else begin : g_pad
            assign lo_tab[k] = '1;
            assign hi_tab[k] = '0;
        end
    end

    logic [NOTE_W-1:0] idx_q, idx_d, code_q, code_d;
    logic              done_q, done_d;
    logic              hit;

    assign hit = (period >= lo_tab[idx_q]) && (period <= hi_tab[idx_q]);

    always_comb begin
        idx_d  = idx_q;
        code_d = code_q;
        done_d = 1'b0;
        if (start) begin
            idx_d  = NOTE_W'(1);
            code_d = '0;
        end else if (idx_q != '0) begin
            if (code_q == '0 && hit) code_d = idx_q;
            if (idx_q == NOTE_W'(NUM_NOTES)) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            code_q <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            code_q <= code_d;
            done_q <= done_d;
        end
    end

    assign busy = (idx_q != '0);
    assign done = done_q;
    assign code = code_q;

endmodule

// File: rtl/note_detector.sv
// Square-wave audio note detector: measures rising-edge period, classifies it
// against the note table and reports a note once it has been stable.
module note_detector
    import music_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE_CNT  = 3,
    parameter int SILENCE_CYC = 2_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    note_detector_if.slave bus
);

    localparam int                  MC_W   = $clog2(STABLE_CNT + 1);
    localparam logic [MC_W-1:0]     MC_MAX = MC_W'(STABLE_CNT);
    localparam logic [PERIOD_W-1:0] SIL    = PERIOD_W'(SILENCE_CYC);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    det_state_e             state_q, state_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d, period_q, period_d;
    logic [NOTE_W-1:0]      cand_q, cand_d, note_q, note_d;
    logic [MC_W-1:0]        mcnt_q, mcnt_d;
    logic                   valid_q, valid_d, chg_q, chg_d;

    logic                   rise, start, busy, done, res_vld, silent;
    logic [NOTE_W-1:0]      code, res, cand_n;
    logic [MC_W-1:0]        mcnt_n;

    note_period_search #(
        .CLK_HZ    (CLK_HZ),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_search (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .period (period_q),
        .busy   (busy),
        .done   (done),
        .code   (code)
    );

    assign sync_d = SYNC_STAGES'({sync_q, bus.audio_in});
    assign prev_d = sync_q[SYNC_STAGES-1];
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cand_d   = cand_q;
        mcnt_d   = mcnt_q;
        note_d   = note_q;
        chg_d    = 1'b0;
        start    = 1'b0;
        res_vld  = 1'b0;
        res      = '0;
        silent   = 1'b0;

        cnt_d = (cnt_q == SIL) ? cnt_q : cnt_q + 1'b1;
        if (rise) cnt_d = PERIOD_W'(1);

        case (state_q)
            IDLE: if (rise) state_d = MEAS;
            MEAS: begin
                if (rise) begin
                    period_d = cnt_q;
                    start    = 1'b1;
                    state_d  = SRCH;
                end else if (cnt_q == SIL) begin
                    silent = 1'b1;
                end
            end
            SRCH: begin
                // An edge mid-scan aborts it (classified as 0) unless the scan
                // finishes on that very cycle, in which case its result stands.
                if (rise) begin
                    period_d = cnt_q;
                    start    = 1'b1;
                    res_vld  = 1'b1;
                    res      = busy ? '0 : code;
                end else if (cnt_q == SIL) begin
                    silent = 1'b1;
                end else if (done) begin
                    res_vld = 1'b1;
                    res     = code;
                    state_d = MEAS;
                end
            end
            default: state_d = IDLE;
        endcase

        cand_n = cand_q;
        mcnt_n = mcnt_q;
        if (res == cand_q) begin
            if (mcnt_q != MC_MAX) mcnt_n = mcnt_q + 1'b1;
        end else begin
            cand_n = res;
            mcnt_n = MC_W'(1);
        end

        if (res_vld) begin
            cand_d = cand_n;
            mcnt_d = mcnt_n;
            if (mcnt_n == MC_MAX && cand_n != note_q) begin
                note_d = cand_n;
                chg_d  = 1'b1;
            end
        end

        if (silent) begin
            state_d = IDLE;
            cand_d  = '0;
            mcnt_d  = '0;
            note_d  = '0;
            chg_d   = (note_q != '0);
        end

        valid_d = (note_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            cand_q   <= '0;
            mcnt_q   <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            cand_q   <= cand_d;
            mcnt_q   <= mcnt_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
        end
    end

    assign bus.note        = note_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_change = chg_q;
    assign bus.period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Scoreboard bench for note_detector with a scaled-down clock so tones fit in
// a short run; expected note_change events are queued as edges are driven.
module tb_note_detector;

    localparam int CLK_HZ = 500_000;
    localparam int TOL    = 6;
    localparam int STABLE = 3;
    localparam int SIL    = 5000;
    localparam int SYNC   = 2;
    localparam int HZ [21] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698,
                               784, 880, 988, 1046, 1175, 1318, 1397, 1568, 1760, 1976};

    typedef struct {
        int cyc;
        int note;
    } exp_t;

    logic clk, rst;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    exp_t sb [$];

    int   m_last = 0, m_cand = 0, m_cnt = 0, m_note = 0;
    bit   m_idle = 1;

    note_detector_if bus();

    note_detector #(
        .CLK_HZ      (CLK_HZ),
        .TOL_SHIFT   (TOL),
        .STABLE_CNT  (STABLE),
        .SILENCE_CYC (SIL),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int classify(input int p);
        for (int k = 0; k < 21; k++) begin
            int q;
            int t;
            q = CLK_HZ / HZ[k];
            t = q >> TOL;
            if (p >= q - t && p <= q + t) return k + 1;
        end
        return 0;
    endfunction

    task automatic push_exp(input int c, input int n);
        exp_t e;
        e.cyc  = c;
        e.note = n;
        sb.push_back(e);
    endtask

    // Rising edge now (at a negedge), high for 4 clocks, next edge 'next' clocks later.
    task automatic send_edge(input int next);
        int r;
        bus.audio_in = 1'b1;
        if (m_idle) begin
            m_idle = 0;
        end else begin
            r = classify(cyc - m_last);
            if (r == m_cand) begin
                if (m_cnt < STABLE) m_cnt++;
            end else begin
                m_cand = r;
                m_cnt  = 1;
            end
            if (m_cnt == STABLE && m_cand != m_note) begin
                m_note = m_cand;
                push_exp(cyc + SYNC + 23, m_note);
            end
        end
        m_last = cyc;
        repeat (4) @(negedge clk);
        bus.audio_in = 1'b0;
        repeat (next - 4) @(negedge clk);
    endtask

    task automatic go_quiet(input int n);
        if (!m_idle && m_note != 0) push_exp(m_last + SYNC + 1 + SIL, 0);
        m_idle = 1;
        m_cand = 0;
        m_cnt  = 0;
        m_note = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_idle = 1;
        m_cand = 0;
        m_cnt  = 0;
        m_note = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.note_change) begin
            if (sb.size() == 0) begin
                chk("spurious_change", int'(bus.note), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("change_note", int'(bus.note), e.note);
                chk("change_cycle", cyc, e.cyc);
                chk("change_valid", int'(bus.note_valid), int'(e.note != 0));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.audio_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bus.audio_in = ~bus.audio_in;
        end
        bus.audio_in = 1'b0;
        chk("rst_note", int'(bus.note), 0);
        chk("rst_valid", int'(bus.note_valid), 0);
        chk("rst_change", int'(bus.note_change), 0);
        chk("rst_period", int'(bus.period), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // A4 lock
        repeat (4) send_edge(1136);
        chk("a4_period", int'(bus.period), 1136);
        chk("a4_valid", int'(bus.note_valid), 1);

        // Jitter inside the window, then outside it
        repeat (2) begin
            send_edge(1151);
            send_edge(1121);
        end
        send_edge(1154);
        chk("jitter_hold", int'(bus.note), 6);
        send_edge(1136);
        send_edge(1154);
        send_edge(1154);
        send_edge(1154);
        chk("jitter_hold2", int'(bus.note), 6);

        // Tone changes C4 -> G4 -> B6
        repeat (3) send_edge(1908);
        repeat (3) send_edge(1275);
        repeat (4) send_edge(253);
        chk("b6_note", int'(bus.note), 21);
        chk("b6_period", int'(bus.period), 253);

        // Silence, then well beyond it
        go_quiet(SIL + 7600);
        chk("sil_note", int'(bus.note), 0);
        chk("sil_valid", int'(bus.note_valid), 0);

        // Unrecognised period, injected edge mid-search, then recovery to A4
        repeat (3) send_edge(150);
        send_edge(10);
        send_edge(1136);
        chk("zero_note", int'(bus.note), 0);
        repeat (3) send_edge(1136);
        chk("recover_note", int'(bus.note), 6);
        send_edge(15);
        chk("srch_period", int'(bus.period), 1136);

        // Async reset in the middle of a search
        #2 rst = 1'b1;
        #1;
        chk("arst_note", int'(bus.note), 0);
        chk("arst_valid", int'(bus.note_valid), 0);
        chk("arst_change", int'(bus.note_change), 0);
        chk("arst_period", int'(bus.period), 0);
        model_reset();
        chk("arst_pending", sb.size(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) send_edge(1275);
        chk("final_note", int'(bus.note), 5);
        chk("final_valid", int'(bus.note_valid), 1);
        chk("final_pending", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
